// File: rtl/lv_lbist_seq.sv
// Multi-channel LV logic-BIST sequencer: runs REQ_NUM req/ack transactions per channel in turn.
// Optional build macro LV_LBIST_RETRY_EN re-runs a failing channel once before its result is final.
module lv_lbist_seq #(
    parameter int unsigned  CH_NUM    = 2,
    parameter int unsigned  REQ_NUM   = 4,
    parameter int unsigned  OK_NUM    = 3,
    parameter int unsigned  CH_TMO_TH = 96000,
    localparam int unsigned CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bist_en,
    output logic [CH_NUM-1:0] o_ch_req,
    input  logic [CH_NUM-1:0] i_ch_ack,
    input  logic [CH_NUM-1:0] i_ch_err,
    output logic [CH_NUM-1:0] o_ch_rult,
    output logic [CH_W-1:0]   o_cur_ch,
    output logic              o_bist_busy,
    output logic              o_lv_bist_done,
    output logic              o_lv_bist_pass
);

    localparam int unsigned RW = $clog2(REQ_NUM + 1);
    localparam int unsigned TW = (CH_TMO_TH > 2) ? $clog2(CH_TMO_TH) : 1;

    localparam logic [RW-1:0]   REQ_MAX = RW'(REQ_NUM);
    localparam logic [RW-1:0]   OK_MIN  = RW'(OK_NUM);
    localparam logic [TW-1:0]   TMO_MAX = TW'(CH_TMO_TH - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);

    if (CH_NUM == 0 || REQ_NUM == 0 || OK_NUM == 0 || OK_NUM > REQ_NUM || CH_TMO_TH < 2)
    begin : g_param_err
        $error("lv_lbist_seq: illegal parameter combination");
    end

    typedef enum logic [2:0] {StIdle, StReq, StWait, StEval, StDone} state_e;

    state_e          state_q;
    logic [CH_W-1:0] ch_q;
    logic [RW-1:0]   req_cnt_q;
    logic [RW-1:0]   ok_cnt_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic            tmo_q;
`ifdef LV_LBIST_RETRY_EN
    logic            retry_q;
`endif

    logic              ack_hit;
    logic              ack_ok;
    logic              final_ack;
    logic              tmo_hit;
    logic              ch_pass;
    logic [RW-1:0]     req_cnt_inc;
    logic [RW-1:0]     ok_cnt_inc;
    logic [TW-1:0]     tmo_cnt_inc;
    logic [CH_NUM-1:0] rult_upd;

    always_comb begin
        // Only the channel under test, while its request is raised, may respond.
        ack_hit     = (state_q == StWait) && i_ch_ack[ch_q];
        ack_ok      = ack_hit && !i_ch_err[ch_q];
        req_cnt_inc = (req_cnt_q == REQ_MAX) ? req_cnt_q : req_cnt_q + 1'b1;
        ok_cnt_inc  = (ok_cnt_q == REQ_MAX) ? ok_cnt_q : ok_cnt_q + 1'b1;
        tmo_cnt_inc = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        final_ack   = ack_hit && (req_cnt_inc == REQ_MAX);
        tmo_hit     = ((state_q == StReq) || (state_q == StWait)) && (tmo_cnt_q == TMO_MAX);
        ch_pass     = (ok_cnt_q >= OK_MIN) && !tmo_q;
        rult_upd    = o_ch_rult;
        rult_upd[ch_q] = ch_pass;
    end

    assign o_cur_ch = ch_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= StIdle;
            ch_q           <= '0;
            req_cnt_q      <= '0;
            ok_cnt_q       <= '0;
            tmo_cnt_q      <= '0;
            tmo_q          <= 1'b0;
`ifdef LV_LBIST_RETRY_EN
            retry_q        <= 1'b0;
`endif
            o_ch_req       <= '0;
            o_ch_rult      <= '0;
            o_bist_busy    <= 1'b0;
            o_lv_bist_done <= 1'b0;
            o_lv_bist_pass <= 1'b0;
        end else if ((state_q != StIdle) && !i_bist_en) begin
            // Abort or release: completed channel results are kept.
            state_q        <= StIdle;
            o_ch_req       <= '0;
            o_bist_busy    <= 1'b0;
            o_lv_bist_done <= 1'b0;
            o_lv_bist_pass <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_bist_en) begin
                        state_q     <= StReq;
                        ch_q        <= '0;
                        req_cnt_q   <= '0;
                        ok_cnt_q    <= '0;
                        tmo_cnt_q   <= '0;
                        tmo_q       <= 1'b0;
`ifdef LV_LBIST_RETRY_EN
                        retry_q     <= 1'b0;
`endif
                        o_ch_rult   <= '0;
                        o_bist_busy <= 1'b1;
                    end
                end
                StReq: begin
                    tmo_cnt_q <= tmo_cnt_inc;
                    if (tmo_hit) begin
                        tmo_q   <= 1'b1;
                        state_q <= StEval;
                    end else begin
                        o_ch_req <= CH_NUM'(1) << ch_q;
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    tmo_cnt_q <= tmo_cnt_inc;
                    if (ack_hit) begin
                        o_ch_req  <= '0;
                        req_cnt_q <= req_cnt_inc;
                        if (ack_ok) begin
                            ok_cnt_q <= ok_cnt_inc;
                        end
                        // A final ack beats a coincident timeout.
                        if (final_ack) begin
                            state_q <= StEval;
                        end else if (tmo_hit) begin
                            tmo_q   <= 1'b1;
                            state_q <= StEval;
                        end else begin
                            state_q <= StReq;
                        end
                    end else if (tmo_hit) begin
                        o_ch_req <= '0;
                        tmo_q    <= 1'b1;
                        state_q  <= StEval;
                    end
                end
                StEval: begin
`ifdef LV_LBIST_RETRY_EN
                    if (!ch_pass && !retry_q) begin
                        retry_q   <= 1'b1;
                        req_cnt_q <= '0;
                        ok_cnt_q  <= '0;
                        tmo_cnt_q <= '0;
                        tmo_q     <= 1'b0;
                        state_q   <= StReq;
                    end else
`endif
                    begin
                        o_ch_rult <= rult_upd;
`ifdef LV_LBIST_RETRY_EN
                        retry_q   <= 1'b0;
`endif
                        if (ch_q == CH_LAST) begin
                            state_q        <= StDone;
                            o_bist_busy    <= 1'b0;
                            o_lv_bist_done <= 1'b1;
                            o_lv_bist_pass <= &rult_upd;
                        end else begin
                            ch_q      <= ch_q + 1'b1;
                            req_cnt_q <= '0;
                            ok_cnt_q  <= '0;
                            tmo_cnt_q <= '0;
                            tmo_q     <= 1'b0;
                            state_q   <= StReq;
                        end
                    end
                end
                StDone: begin
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lv_lbist_seq.sv
// Scoreboard bench for lv_lbist_seq: directed runs push expected end-of-sequence records,
// a monitor pops one each time busy falls and compares results and request counts.
module tb_lv_lbist_seq;

    localparam int unsigned TMO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] ch_ack;
    logic [1:0] ch_err;
    logic [1:0] ch_req;
    logic [1:0] ch_rult;
    logic       cur_ch;
    logic       busy;
    logic       done;
    logic       pass;

    lv_lbist_seq #(
        .CH_NUM   (2),
        .REQ_NUM  (4),
        .OK_NUM   (3),
        .CH_TMO_TH(TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_bist_en     (en),
        .o_ch_req      (ch_req),
        .i_ch_ack      (ch_ack),
        .i_ch_err      (ch_err),
        .o_ch_rult     (ch_rult),
        .o_cur_ch      (cur_ch),
        .o_bist_busy   (busy),
        .o_lv_bist_done(done),
        .o_lv_bist_pass(pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       done;
        logic [1:0] rult;
        logic       pass;
        int         r0;
        int         r1;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   ev_cnt  = 0;
    int   req_seen[2];
    logic [1:0] req_prev  = 2'b00;
    logic       busy_prev = 1'b0;

    logic [1:0] resp_on;
    int         lat[2];
    logic [7:0] err_mask[2];
    int         idx[2];
    int         cnt;
    logic       stray;

    task automatic check(input string name, input int id, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (run %0d): got %0d, want %0d", name, id, act, exp);
    endtask

    task automatic setup(input logic [1:0] on, input int l0, input int l1,
                         input logic [7:0] m0, input logic [7:0] m1, input logic s);
        resp_on     = on;
        lat[0]      = l0;
        lat[1]      = l1;
        err_mask[0] = m0;
        err_mask[1] = m1;
        idx[0]      = 0;
        idx[1]      = 0;
        stray       = s;
    endtask

    task automatic expect_end(input int id, input logic d, input logic [1:0] r, input logic p,
                              input int r0, input int r1);
        exp_t e;
        e.id = id; e.done = d; e.rult = r; e.pass = p; e.r0 = r0; e.r1 = r1;
        sb.push_back(e);
    endtask

    task automatic wait_end(input int id);
        int start;
        int n;
        start = ev_cnt;
        n     = 0;
        while (ev_cnt == start && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("end_seen", id, int'(ev_cnt != start), 1);
    endtask

    task automatic run(input int id, input logic [1:0] rult_exp);
        @(posedge clk); #1 en = 1'b1;
        wait_end(id);
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); #1;
        check("done_clr", id, int'(done), 0);
        check("pass_clr", id, int'(pass), 0);
        check("rult_hold", id, int'(ch_rult), int'(rult_exp));
    endtask

    // Responder: acks the live request after lat[ch] cycles; optional stray acks with err=1.
    initial begin
        logic [1:0] ack_v;
        logic [1:0] err_v;
        int         c;
        ch_ack = '0;
        ch_err = '0;
        cnt    = 0;
        forever begin
            @(posedge clk); #1;
            ack_v = '0;
            err_v = '0;
            c     = int'(cur_ch);
            if (ch_req != 2'b00) begin
                cnt++;
                if (resp_on[c] && cnt == lat[c]) begin
                    ack_v[c] = 1'b1;
                    if (idx[c] < 8) err_v[c] = err_mask[c][idx[c]];
                    idx[c]++;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
            if (stray) begin
                if (c == 0) begin
                    ack_v[1] = 1'b1;
                    err_v[1] = 1'b1;
                end
                if (ch_req == 2'b00 && busy) begin
                    ack_v[c] = 1'b1;
                    err_v[c] = 1'b1;
                end
            end
            ch_ack = ack_v;
            ch_err = err_v;
        end
    end

    // Monitor: end of a sequence is busy falling (done or abort).
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !busy_prev) begin
                req_seen[0] = 0;
                req_seen[1] = 0;
            end
            for (int c = 0; c < 2; c++) begin
                if (ch_req[c] && !req_prev[c]) req_seen[c]++;
            end
            if (!busy && busy_prev) begin
                check("sb_has_entry", -1, int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done", e.id, int'(done), int'(e.done));
                    check("rult", e.id, int'(ch_rult), int'(e.rult));
                    check("pass", e.id, int'(pass), int'(e.pass));
                    check("req_low", e.id, int'(ch_req), 0);
                    check("reqs_ch0", e.id, req_seen[0], e.r0);
                    check("reqs_ch1", e.id, req_seen[1], e.r1);
                end
                ev_cnt++;
            end
        end
        busy_prev = busy;
        req_prev  = ch_req;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        en  = 1'b0;
        setup(2'b11, 3, 3, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req", 0, int'(ch_req), 0);
        check("rst_rult", 0, int'(ch_rult), 0);
        check("rst_cur", 0, int'(cur_ch), 0);
        check("rst_busy", 0, int'(busy), 0);
        check("rst_done", 0, int'(done), 0);
        check("rst_pass", 0, int'(pass), 0);

        // 1: clean run on both channels.
        setup(2'b11, 3, 3, 8'h00, 8'h00, 1'b0);
        expect_end(1, 1'b1, 2'b11, 1'b1, 4, 4);
        run(1, 2'b11);

        // 2: ch1 errors on 2 of 4 acks.
        setup(2'b11, 3, 3, 8'h00, 8'h05, 1'b0);
`ifdef LV_LBIST_RETRY_EN
        expect_end(2, 1'b1, 2'b11, 1'b1, 4, 8);
        run(2, 2'b11);
`else
        expect_end(2, 1'b1, 2'b01, 1'b0, 4, 4);
        run(2, 2'b01);
`endif

        // 2b: exactly OK_NUM clean acks still passes.
        setup(2'b11, 3, 3, 8'h01, 8'h00, 1'b0);
        expect_end(21, 1'b1, 2'b11, 1'b1, 4, 4);
        run(21, 2'b11);

        // 3: ch0 never acks.
        setup(2'b10, 3, 3, 8'h00, 8'h00, 1'b0);
`ifdef LV_LBIST_RETRY_EN
        expect_end(3, 1'b1, 2'b10, 1'b0, 2, 4);
`else
        expect_end(3, 1'b1, 2'b10, 1'b0, 1, 4);
`endif
        run(3, 2'b10);

        // 4: final ack lands on the timeout cycle (4*(9+1)-1 == TMO-1).
        setup(2'b11, 9, 3, 8'h00, 8'h00, 1'b0);
        expect_end(4, 1'b1, 2'b11, 1'b1, 4, 4);
        run(4, 2'b11);

        // 4b: one cycle slower and the channel times out.
        setup(2'b11, 10, 3, 8'h00, 8'h00, 1'b0);
`ifdef LV_LBIST_RETRY_EN
        expect_end(41, 1'b1, 2'b10, 1'b0, 8, 4);
`else
        expect_end(41, 1'b1, 2'b10, 1'b0, 4, 4);
`endif
        run(41, 2'b10);

        // 6: stray acks on the wrong channel and in request gaps.
        setup(2'b11, 3, 3, 8'h00, 8'h00, 1'b1);
        expect_end(6, 1'b1, 2'b11, 1'b1, 4, 4);
        run(6, 2'b11);
        stray = 1'b0;

        // 5: abort during ch1 wait, then restart.
        setup(2'b11, 3, 3, 8'h00, 8'h00, 1'b0);
        expect_end(5, 1'b0, 2'b01, 1'b0, 4, 1);
        @(posedge clk); #1 en = 1'b1;
        n = 0;
        while (!(cur_ch == 1'b1 && ch_req[1]) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_point", 5, int'(cur_ch == 1'b1 && ch_req[1]), 1);
        en = 1'b0;
        wait_end(5);
        setup(2'b11, 3, 3, 8'h00, 8'h00, 1'b0);
        expect_end(51, 1'b1, 2'b11, 1'b1, 4, 4);
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1;
        check("restart_rult", 51, int'(ch_rult), 0);
        check("restart_busy", 51, int'(busy), 1);
        check("restart_ch", 51, int'(cur_ch), 0);
        wait_end(51);
        @(posedge clk); #1 en = 1'b0;
        repeat (2) @(posedge clk);

        // 7: reset in the middle of ch1.
        setup(2'b11, 3, 3, 8'h00, 8'h00, 1'b0);
        #1 en = 1'b1;
        n = 0;
        while (cur_ch != 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_rst_point", 7, int'(cur_ch), 1);
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("mrst_req", 7, int'(ch_req), 0);
        check("mrst_rult", 7, int'(ch_rult), 0);
        check("mrst_cur", 7, int'(cur_ch), 0);
        check("mrst_busy", 7, int'(busy), 0);
        repeat (3) @(posedge clk);

        check("sb_drained", 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
